// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - Instruction/data client and shared memory signals of mem_arbiter
// slave: the arbiter's view; master: the clients plus memory driving the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Two-client (instruction/data) arbiter onto one shared memory port
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is data-side priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic                  i_req;
    logic                  d_req;
    logic                  grant_i;
    logic                  grant_d;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

`ifdef MEM_ARB_RR_EN
    logic last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (state == IDLE && (grant_i || grant_d)) begin
            last_d <= grant_d;
        end
    end

    // On a tie the side that did not win last time gets the memory.
    assign grant_d = d_req && (!i_req || !last_d);
`else
    assign grant_d = d_req;
`endif
    assign grant_i = i_req && !grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory outputs come only from these registers, so client changes mid-service are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                addr_q  <= bus.d_address;
                wdata_q <= bus.d_wdata;
                write_q <= bus.d_write;
            end else if (grant_i) begin
                addr_q  <= bus.i_address;
                wdata_q <= '0;
                write_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = SERVE_D;
                end else if (grant_i) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp == 1'b1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = addr_q;
        bus.mem_wdata   = wdata_q;
        bus.i_resp      = 1'b0;
        bus.d_resp      = 1'b0;
        bus.i_rdata     = bus.mem_rdata;
        bus.d_rdata     = bus.mem_rdata;
        if (state == SERVE_I || state == SERVE_D) begin
            bus.mem_read  = !write_q;
            bus.mem_write = write_q;
        end
        if (state == SERVE_I) begin
            bus.i_resp = (bus.mem_resp == 1'b1);
        end
        if (state == SERVE_D) begin
            bus.d_resp = (bus.mem_resp == 1'b1);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Self-checking bench for mem_arbiter: vector table, corner sequences, random vs model
// Expected results follow the MEM_ARB_RR_EN setting of the build.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 128;
    localparam logic [DW-1:0] A5 = {16{8'hA5}};
    localparam logic [DW-1:0] W1 = {4{32'hDEAD_BEEF}};
    localparam logic [DW-1:0] W3 = {4{32'hCAFE_F00D}};
    localparam logic [DW-1:0] R2 = {4{32'h1234_5678}};
    localparam logic [DW-1:0] R3 = {4{32'h0BAD_C0DE}};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dwd;
        logic          mr;
        logic [DW-1:0] mrd;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic          e_ir;
        logic          e_dr;
    } vec_t;

    vec_t tbl[21];

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level reference: who owns the memory, the granted request, and the gap cycle.
    int            m_owner;
    bit            m_gap;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_last_d;

    logic [AW-1:0] rr_exp[4];
    logic [AW-1:0] got;
    bit            found;
    bit            i_seen;
    bit            d_seen;
    int            op;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = '0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        m_owner  = 0;
        m_gap    = 1'b0;
        m_wr     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_last_d = 1'b0;
    endtask

    task automatic model_check_and_step();
        bit exp_rd, exp_wr, exp_ir, exp_dr, dq, iq, take_d;
        exp_rd = (m_owner != 0) && !m_wr;
        exp_wr = (m_owner != 0) && m_wr;
        exp_ir = (m_owner == 1) && bus.mem_resp;
        exp_dr = (m_owner == 2) && bus.mem_resp;
        chk("rnd_mem_read", bus.mem_read, exp_rd);
        chk("rnd_mem_write", bus.mem_write, exp_wr);
        chk("rnd_mem_address", bus.mem_address, m_addr);
        chk("rnd_i_resp", bus.i_resp, exp_ir);
        chk("rnd_d_resp", bus.d_resp, exp_dr);
        if (exp_wr) chk("rnd_mem_wdata", bus.mem_wdata, m_wdata);
        if (exp_ir) chk("rnd_i_rdata", bus.i_rdata, bus.mem_rdata);
        if (exp_dr && !m_wr) chk("rnd_d_rdata", bus.d_rdata, bus.mem_rdata);
        if (m_owner != 0) begin
            if (bus.mem_resp) begin
                m_owner = 0;
                m_gap   = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            dq = bus.d_read | bus.d_write;
            iq = bus.i_read;
            if (dq && iq) begin
`ifdef MEM_ARB_RR_EN
                take_d = !m_last_d;
`else
                take_d = 1'b1;
`endif
            end else begin
                take_d = dq;
            end
            if (take_d) begin
                m_owner = 2;
                m_addr  = bus.d_address;
                m_wdata = bus.d_wdata;
                m_wr    = bus.d_write;
                m_last_d = 1'b1;
            end else if (iq) begin
                m_owner = 1;
                m_addr  = bus.i_address;
                m_wr    = 1'b0;
                m_last_d = 1'b0;
            end
        end
    endtask

    initial begin
        //         ir    ia        dr    dw    da        dwd  mr    mrd  e_rd  e_wr  e_addr    e_ir  e_dr
        tbl[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, '0, 1'b1, A5, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, '0, 1'b0, '0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, '0, 1'b0, '0, 1'b1, 1'b0, 16'h0040, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, '0, 1'b0, '0, 1'b1, 1'b0, 16'h0040, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, '0, 1'b1, A5, 1'b1, 1'b0, 16'h0040, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, '0, 1'b1, A5, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, '0, 1'b1, A5, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'h0080, 1'b0, 1'b1, 16'h0100, W1, 1'b0, '0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'h0080, 1'b0, 1'b1, 16'h0100, W1, 1'b0, '0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 16'h0080, 1'b0, 1'b1, 16'h0200, W1, 1'b1, '0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, '0, 1'b0, '0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, '0, 1'b0, '0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, '0, 1'b1, R2, 1'b1, 1'b0, 16'h0080, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, '0, 1'b0, '0, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0300, W3, 1'b0, '0, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0300, W3, 1'b1, '0, 1'b0, 1'b1, 16'h0300, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, '0, 1'b0, '0, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, '0, 1'b0, '0, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, '0, 1'b0, '0, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, '0, 1'b1, R3, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, '0, 1'b0, '0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

`ifdef MEM_ARB_RR_EN
        rr_exp[0] = 16'h0022; rr_exp[1] = 16'h0011; rr_exp[2] = 16'h0022; rr_exp[3] = 16'h0011;
`else
        rr_exp[0] = 16'h0022; rr_exp[1] = 16'h0022; rr_exp[2] = 16'h0022; rr_exp[3] = 16'h0022;
`endif

        rst_n = 1'b0;
        clear_inputs();
        #3;
        chk("reset_mem_read", bus.mem_read, 1'b0);
        chk("reset_mem_write", bus.mem_write, 1'b0);
        chk("reset_mem_address", bus.mem_address, '0);
        chk("reset_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            bus.i_read    = tbl[i].ir;
            bus.i_address = tbl[i].ia;
            bus.d_read    = tbl[i].dr;
            bus.d_write   = tbl[i].dw;
            bus.d_address = tbl[i].da;
            bus.d_wdata   = tbl[i].dwd;
            bus.mem_resp  = tbl[i].mr;
            bus.mem_rdata = tbl[i].mrd;
            #1;
            chk($sformatf("vec%0d_mem_read", i), bus.mem_read, tbl[i].e_rd);
            chk($sformatf("vec%0d_mem_write", i), bus.mem_write, tbl[i].e_wr);
            chk($sformatf("vec%0d_mem_address", i), bus.mem_address, tbl[i].e_addr);
            chk($sformatf("vec%0d_i_resp", i), bus.i_resp, tbl[i].e_ir);
            chk($sformatf("vec%0d_d_resp", i), bus.d_resp, tbl[i].e_dr);
            if (tbl[i].e_wr) chk($sformatf("vec%0d_mem_wdata", i), bus.mem_wdata, tbl[i].dwd);
            if (tbl[i].e_ir) chk($sformatf("vec%0d_i_rdata", i), bus.i_rdata, tbl[i].mrd);
            if (tbl[i].e_dr && !tbl[i].e_wr) chk($sformatf("vec%0d_d_rdata", i), bus.d_rdata, tbl[i].mrd);
        end

        // Asynchronous reset in the middle of a data write.
        @(negedge clk);
        bus.d_write   = 1'b1;
        bus.d_address = 16'h0400;
        bus.d_wdata   = W1;
        @(negedge clk);
        #1;
        chk("rst_serve_mem_write", bus.mem_write, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_mem_write", bus.mem_write, 1'b0);
        bus.mem_resp = 1'b1;
        #1;
        chk("rst_no_d_resp", bus.d_resp, 1'b0);
        chk("rst_addr_cleared", bus.mem_address, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_resp = 1'b0;
        #1;
        chk("rst_release_idle", bus.mem_write, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_restart_write", bus.mem_write, 1'b1);
        chk("rst_restart_addr", bus.mem_address, 16'h0400);
        bus.mem_resp = 1'b1;
        #1;
        chk("rst_restart_d_resp", bus.d_resp, 1'b1);
        @(negedge clk);
        clear_inputs();

        // Both sides requesting continuously: grant order after reset.
        pulse_reset();
        bus.i_read    = 1'b1;
        bus.i_address = 16'h0011;
        bus.d_read    = 1'b1;
        bus.d_address = 16'h0022;
        for (int t = 0; t < 4; t++) begin
            found = 1'b0;
            got   = '0;
            for (int w = 0; w < 10 && !found; w++) begin
                @(negedge clk);
                bus.mem_resp = 1'b0;
                #1;
                if (bus.mem_read) begin
                    found = 1'b1;
                    got   = bus.mem_address;
                    bus.mem_resp = 1'b1;
                end
            end
            if (!found) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rr_grant%0d: no grant within 10 cycles", t);
            end else begin
                chk($sformatf("rr_grant%0d", t), got, rr_exp[t]);
            end
        end
        @(negedge clk);
        clear_inputs();

        // Random clients and memory against the reference model.
        pulse_reset();
        i_seen = 1'b0;
        d_seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (i_seen) begin
                bus.i_read    = ($urandom % 4 == 0);
                bus.i_address = AW'($urandom);
            end else if (!bus.i_read) begin
                if ($urandom % 3 == 0) begin
                    bus.i_read    = 1'b1;
                    bus.i_address = AW'($urandom);
                end
            end else if ($urandom % 20 == 0) begin
                bus.i_read = 1'b0;
            end
            if (d_seen || (!bus.d_read && !bus.d_write && $urandom % 3 == 0)) begin
                op = int'($urandom % 4);
                bus.d_read    = (op == 1) || (op == 3);
                bus.d_write   = (op == 2) || (op == 3);
                bus.d_address = AW'($urandom);
                bus.d_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end else if ((bus.d_read || bus.d_write) && $urandom % 20 == 0) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end else if ((bus.d_read || bus.d_write) && $urandom % 8 == 0) begin
                bus.d_address = AW'($urandom);
                bus.d_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end
            bus.mem_resp  = ($urandom % 3 == 0);
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            i_seen = bus.i_resp;
            d_seen = bus.d_resp;
            model_check_and_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, physical memory address width.
REQ-002 Parameter DATA_WIDTH, default 128, memory line width.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Ports i_read/i_address  input  1/ADDR_WIDTH  instruction-side read request, held until i_resp.
REQ-006 Ports i_rdata/i_resp  output  DATA_WIDTH/1  instruction-side read data and completion pulse.
REQ-007 Ports d_read/d_write/d_address/d_wdata  input  1/1/ADDR_WIDTH/DATA_WIDTH  data-side request, held until d_resp.
REQ-008 Ports d_rdata/d_resp  output  DATA_WIDTH/1  data-side read data and completion pulse.
REQ-009 Ports mem_read/mem_write/mem_address/mem_wdata  output  1/1/ADDR_WIDTH/DATA_WIDTH  shared physical memory request.
REQ-010 Ports mem_rdata/mem_resp  input  DATA_WIDTH/1  shared memory read data and completion.

Function
REQ-011 FSM states: IDLE, SERVE_I, SERVE_D, DONE; exactly one state at a time.
REQ-012 IDLE: no request pending -> stay IDLE; mem_read=mem_write=0.
REQ-013 IDLE, only i_read -> SERVE_I next edge; only d_read or d_write -> SERVE_D next edge.
REQ-014 IDLE, both sides requesting -> winner per REQ-029/030; loser stays pending, unacknowledged.
REQ-015 On grant edge, address, wdata and op (read/write) of the winner are latched; memory outputs driven only from latched values.
REQ-016 Latency: request seen in IDLE at cycle N -> mem_read/mem_write high from cycle N+1.
REQ-017 SERVE_x holds mem_* outputs stable until mem_resp=1; requester input changes during service are ignored.
REQ-018 mem_resp=1 in SERVE_I -> i_resp=1 same cycle (combinational), i_rdata=mem_rdata; next state DONE.
REQ-019 mem_resp=1 in SERVE_D -> d_resp=1 same cycle, d_rdata=mem_rdata (don't-care on write); next state DONE.
REQ-020 i_resp/d_resp never high outside SERVE_I/SERVE_D respectively; never both high; exactly one cycle per transaction.
REQ-021 DONE: mem_read=mem_write=0, all requests ignored, unconditional -> IDLE; guarantees one idle memory cycle between transactions and filters stale requests.
REQ-022 d_read and d_write both high in IDLE -> treated as write.
REQ-023 mem_resp outside SERVE_x, or X/Z mem_resp, is ignored; no state change, no client resp.
REQ-024 Requester dropping its request mid-service: transaction still completes; resp still pulsed.
REQ-025 mem_read and mem_write never simultaneously high.
REQ-026 Back-to-back: pending loser granted in first IDLE after DONE; max wait for any requester = one full transaction plus 2 cycles.

Reset
REQ-027 rst_n low: immediately (asynchronously) state=IDLE, mem_read=mem_write=0, i_resp=d_resp=0, latches cleared to 0, last-grant flag=instruction.
REQ-028 Reset during SERVE_x aborts the transaction; no resp issued; after release arbitration restarts from IDLE with current requests.

Configuration
REQ-029 Without MEM_ARB_RR_EN: fixed priority, data side always wins simultaneous requests.
REQ-030 With MEM_ARB_RR_EN: one-bit last-grant flag updated on each grant; on simultaneous requests the side not granted last wins; single requests granted regardless of flag.

Verification
REQ-031 Single i_read, i_address=16'h0040, mem_resp after 3 cycles with mem_rdata=128'hA5..A5 -> mem_read high cycle N+1..N+3, i_resp one cycle with i_rdata=A5..A5, DONE, IDLE.
REQ-032 d_write and i_read raised same cycle, no macro -> data write served first (mem_write, d_wdata on bus), then DONE, then i_read served; i_resp only after d_resp+2 cycles.
REQ-033 With MEM_ARB_RR_EN, both sides continuously requesting for 4 transactions -> grant order D,I,D,I (flag reset=I).
REQ-034 d_address changed mid-service from 16'h0100 to 16'h0200 -> mem_address stays 16'h0100 until mem_resp.
REQ-035 rst_n pulsed low mid SERVE_D -> mem_write drops same cycle without clock edge, no d_resp, restart from IDLE.
REQ-036 Spurious mem_resp in IDLE and DONE -> no i_resp/d_resp, state unchanged.
